seq_divider: RTL and testbench

- Sequential signed integer divider; the division counterpart of the team's Booth multiplier datapath.
- The multiplier shifts its product register right. This block shifts a combined remainder/quotient register left, one quotient bit per clock, using restoring division on operand magnitudes.
- Sits beside the multiplier in the arithmetic unit with the same start/done handshake style.

---
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential signed integer divider.
// Restoring division on operand magnitudes. A combined remainder/quotient
// register shifts left by one bit per clock. Signs are applied in a final
// FIX cycle.
//
// Handshake: start is sampled only in IDLE. busy rises on the edge that
// accepts start and falls on the edge that raises done. done is a one-cycle
// pulse. Results hold until the next accepted start reaches FIX.
//
// Optional build macro SEQ_DIV_EARLY_OUT_EN: when |dividend| < |divisor|
// (divisor non-zero), skip the iterations and finish after one edge.
// Results are the same in both builds; only the latency changes.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_q;     // partial remainder magnitude
  logic [WIDTH-1:0] quo_q;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_mag;   // divisor magnitude
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;
  logic             zero_q;

  logic [WIDTH-1:0] dvd_in_mag;
  logic [WIDTH-1:0] dvs_in_mag;
  logic             early;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] rem_signed;

  assign state_dbg = state;

  // Operand magnitudes, trial subtraction and sign fix-up. The partial
  // remainder is conceptually WIDTH+1 bits wide, but after each restoring
  // step it is always below the divisor magnitude. So only the shifted
  // trial value needs the extra bit. The kept difference always fits in
  // WIDTH bits.
  always_comb begin
    dvd_in_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    dvs_in_mag = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
`ifdef SEQ_DIV_EARLY_OUT_EN
    early = (divisor != '0) && (dvd_in_mag < dvs_in_mag);
`else
    early = 1'b0;
`endif
    shifted    = {rem_q, quo_q[WIDTH-1]};
    ge         = (shifted >= {1'b0, dvs_mag});
    trial      = shifted[WIDTH-1:0] - dvs_mag;
    rem_signed = sign_r ? ('0 - rem_q) : rem_q;
  end

  // Control FSM and datapath registers. clr has priority over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_mag     <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r      <= dividend[WIDTH-1];
            zero_q      <= (divisor == '0);
            dvs_mag     <= dvs_in_mag;
            count       <= CW'(WIDTH);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if ((divisor == '0) || early) begin
              // No iterations needed. The remainder magnitude is the
              // dividend magnitude, so FIX restores the original dividend.
              quo_q <= '0;
              rem_q <= dvd_in_mag;
              state <= FIX;
            end else begin
              quo_q <= dvd_in_mag;
              rem_q <= '0;
              state <= ITER;
            end
          end
        end
        ITER: begin
          rem_q <= ge ? trial : shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ge};
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          remainder <= rem_signed;
          state     <= IDLE;
          if (zero_q) begin
            quotient    <= '1;
            div_by_zero <= 1'b1;
          end else begin
            quotient <= sign_q ? ('0 - quo_q) : quo_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven bench for seq_divider (WIDTH=32), plus
// hand-written sequences for clr mid-operation and start/clr collisions.
// Handshake: start is sampled only in IDLE. busy runs from the accept edge
// to the edge that raises done. done is a one-cycle pulse.
module tb_seq_divider;

  localparam int W = 32;
`ifdef SEQ_DIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = W + 1;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           poke;   // edge index after which a stray start is pulsed, -1 none
  } vec_t;

  logic         clk;
  logic         clr;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  int           tests;
  int           fails;
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;
  vec_t         vecs[16];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: stop a run that has hung.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Run one operation. Checks the accept edge, the latency, the busy span,
  // the results, the single-cycle done pulse, and that results hold.
  task automatic run_op(input vec_t v, input string nm);
    int k;
    int busy_cnt;
    int done_cnt;
    int busy_late;
    @(negedge clk);
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    chk({nm, "_busy0"}, W'(busy), W'(1));
    chk({nm, "_done0"}, W'(done), W'(0));
    chk({nm, "_dbz0"}, W'(div_by_zero), W'(0));
    chk({nm, "_qhold0"}, quotient, prev_q);
    chk({nm, "_rhold0"}, remainder, prev_r);
    k = 0;
    busy_cnt = 1;
    while (done !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
      if (busy === 1'b1) busy_cnt++;
      if (k == v.poke) begin
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd1;
      end
    end
    chk({nm, "_lat"}, W'(k), W'(v.lat));
    chk({nm, "_busycnt"}, W'(busy_cnt), W'(v.lat));
    chk({nm, "_q"}, quotient, v.q);
    chk({nm, "_r"}, remainder, v.r);
    chk({nm, "_dbz"}, W'(div_by_zero), W'(v.dbz));
    done_cnt  = 0;
    busy_late = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_late++;
    end
    chk({nm, "_donepulse"}, W'(done_cnt), W'(0));
    chk({nm, "_busyidle"}, W'(busy_late), W'(0));
    chk({nm, "_q_hold"}, quotient, v.q);
    chk({nm, "_r_hold"}, remainder, v.r);
    chk({nm, "_dbz_hold"}, W'(div_by_zero), W'(v.dbz));
    prev_q = v.q;
    prev_r = v.r;
  endtask

  // Check that every output (and the debug state) is back at its cleared value.
  task automatic chk_cleared(input string nm);
    chk({nm, "_busy"}, W'(busy), W'(0));
    chk({nm, "_done"}, W'(done), W'(0));
    chk({nm, "_q"}, quotient, '0);
    chk({nm, "_r"}, remainder, '0);
    chk({nm, "_dbz"}, W'(div_by_zero), W'(0));
    chk({nm, "_state"}, W'(state_dbg), W'(0));
  endtask

  initial begin
    int done_cnt;
    tests    = 0;
    fails    = 0;
    prev_q   = '0;
    prev_r   = '0;
    clr      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vecs[0]  = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, W + 1, -1};
    vecs[1]  = '{-32'd100,     32'd7,          -32'd14,        -32'd2,         1'b0, W + 1, -1};
    vecs[2]  = '{32'd100,      -32'd7,         -32'd14,        32'd2,          1'b0, W + 1, -1};
    vecs[3]  = '{-32'd100,     -32'd7,         32'd14,         -32'd2,         1'b0, W + 1, -1};
    vecs[4]  = '{32'd5,        32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1,     -1};
    vecs[5]  = '{32'd9,        32'd3,          32'd3,          32'd0,          1'b0, W + 1, -1};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, W + 1, -1};
    vecs[7]  = '{32'h80000000, 32'd1,          32'h80000000,   32'd0,          1'b0, W + 1, -1};
    vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF,   32'd1,          32'd0,          1'b0, W + 1, -1};
    vecs[9]  = '{32'd3,        32'd7,          32'd0,          32'd3,          1'b0, EL,    -1};
    vecs[10] = '{32'd0,        -32'd5,         32'd0,          32'd0,          1'b0, EL,    -1};
    vecs[11] = '{-32'd3,       32'd7,          32'd0,          -32'd3,         1'b0, EL,    -1};
    vecs[12] = '{-32'd7,       32'd0,          32'hFFFFFFFF,   -32'd7,         1'b1, 1,     -1};
    vecs[13] = '{32'd1000,     32'd10,         32'd100,        32'd0,          1'b0, W + 1, 5};
    vecs[14] = '{32'd50,       32'd5,          32'd10,         32'd0,          1'b0, W + 1, W};
    vecs[15] = '{32'h80000000, 32'h80000000,   32'd1,          32'd0,          1'b0, W + 1, -1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    @(negedge clk);
    clr = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i], $sformatf("v%0d", i));
    end

    // clr after iteration 10 of a 1000/10: outputs clear, no done follows.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk_cleared("clrmid");
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
    chk("clrmid_nodone", W'(done_cnt), W'(0));
    prev_q = '0;
    prev_r = '0;

    // start and clr in the same cycle: stay IDLE.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    clr   = 1'b0;
    chk_cleared("startclr");
    @(posedge clk);
    #1;
    chk("startclr_state2", W'(state_dbg), W'(0));
    chk("startclr_busy2", W'(busy), W'(0));

    // A fresh start is accepted after the collision.
    run_op(vecs[5], "after_clr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
